// File: rtl/axi_lite_cmd_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_master_if
// Groups the bus-side signals of axi_lite_cmd_master into one bundle:
//   s_axis_cmd_*  : command stream in. tdata = {wdata[31:0], addr[31:0]},
//                   tuser = {wstrb[3:0], op}, where op is 1 for write and 0 for read.
//   m_axis_rsp_*  : response stream out. tdata = read data (0 for writes),
//                   tuser = {resp[1:0], op}.
//   m_axi_*       : AXI4-Lite manager channels AW, W, B, AR and R.
// Modports:
//   master : the command master's view (drives AXI requests and responses).
//   slave  : the view of the environment around it (command source, response
//            sink and AXI subordinate).
// -----------------------------------------------------------------------------
interface axi_lite_cmd_master_if;
    logic [63:0] s_axis_cmd_tdata;
    logic [4:0]  s_axis_cmd_tuser;
    logic        s_axis_cmd_tvalid;
    logic        s_axis_cmd_tready;

    logic [31:0] m_axis_rsp_tdata;
    logic [2:0]  m_axis_rsp_tuser;
    logic        m_axis_rsp_tvalid;
    logic        m_axis_rsp_tready;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;

    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;

    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;

    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        input  s_axis_cmd_tdata, s_axis_cmd_tuser, s_axis_cmd_tvalid,
        output s_axis_cmd_tready,
        output m_axis_rsp_tdata, m_axis_rsp_tuser, m_axis_rsp_tvalid,
        input  m_axis_rsp_tready,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output s_axis_cmd_tdata, s_axis_cmd_tuser, s_axis_cmd_tvalid,
        input  s_axis_cmd_tready,
        input  m_axis_rsp_tdata, m_axis_rsp_tuser, m_axis_rsp_tvalid,
        output m_axis_rsp_tready,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_master
// Turns single-beat commands into AXI4-Lite write or read transactions, with
// one transaction outstanding at a time, and returns one response beat per
// command.
// Ports:
//   aclk       : clock, rising edge.
//   aresetn    : asynchronous active-low reset.
//   bus        : axi_lite_cmd_master_if.master (command stream, response
//                stream, AXI4-Lite manager channels).
//   busy       : high from command accept until the response beat is taken.
//   err_count  : saturating count of responses whose resp is not OKAY.
// Every output comes straight from a flop, so no output depends
// combinationally on any ready input.
// -----------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_lite_cmd_master_if.master bus,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    // Saturating increment: an all-ones count stays put instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
        logic [ERR_CNT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    state_t               state_q,      state_d;
    logic                 cmd_tready_q, cmd_tready_d;
    logic                 awvalid_q,    awvalid_d;
    logic                 wvalid_q,     wvalid_d;
    logic                 arvalid_q,    arvalid_d;
    logic                 bready_q,     bready_d;
    logic                 rready_q,     rready_d;
    logic                 rsp_tvalid_q, rsp_tvalid_d;
    logic [31:0]          addr_q,       addr_d;
    logic [31:0]          wdata_q,      wdata_d;
    logic [3:0]           wstrb_q,      wstrb_d;
    logic                 op_q,         op_d;
    logic [31:0]          rsp_data_q,   rsp_data_d;
    logic [1:0]           rsp_resp_q,   rsp_resp_d;
    logic                 busy_q,       busy_d;
    logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;

    // A write channel is still pending if its valid is up and was not taken this cycle.
    logic                 aw_pend_s;
    logic                 w_pend_s;

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cmd_tready_d = cmd_tready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        rready_d     = rready_q;
        rsp_tvalid_d = rsp_tvalid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
        rsp_resp_d   = rsp_resp_q;
        busy_d       = busy_q;
        err_count_d  = err_count_q;
        aw_pend_s    = awvalid_q & ~bus.m_axi_awready;
        w_pend_s     = wvalid_q  & ~bus.m_axi_wready;

        case (state_q)
            ST_IDLE: begin
                if (cmd_tready_q && bus.s_axis_cmd_tvalid) begin
                    // Word-align the address; the subordinate only decodes 32-bit registers.
                    addr_d       = {bus.s_axis_cmd_tdata[31:2], 2'b00};
                    wdata_d      = bus.s_axis_cmd_tdata[63:32];
                    wstrb_d      = bus.s_axis_cmd_tuser[4:1];
                    op_d         = bus.s_axis_cmd_tuser[0];
                    cmd_tready_d = 1'b0;
                    busy_d       = 1'b1;
                    if (bus.s_axis_cmd_tuser[0]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end else begin
                    // Also raises tready on the first cycle after reset release.
                    cmd_tready_d = 1'b1;
                end
            end

            ST_WRITE: begin
                // AW and W complete independently, in either order.
                awvalid_d = aw_pend_s;
                wvalid_d  = w_pend_s;
                if (!aw_pend_s && !w_pend_s) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end else begin
                    state_d  = ST_WRITE;
                end
            end

            ST_WRESP: begin
                if (bready_q && bus.m_axi_bvalid) begin
                    bready_d     = 1'b0;
                    rsp_data_d   = 32'h0000_0000;
                    rsp_resp_d   = bus.m_axi_bresp;
                    rsp_tvalid_d = 1'b1;
                    state_d      = ST_RSP;
                    if (bus.m_axi_bresp != 2'b00) begin
                        err_count_d = sat_inc(err_count_q);
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    state_d = ST_WRESP;
                end
            end

            ST_READ: begin
                if (arvalid_q && bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end else begin
                    state_d = ST_READ;
                end
            end

            ST_RDATA: begin
                if (rready_q && bus.m_axi_rvalid) begin
                    rready_d     = 1'b0;
                    rsp_data_d   = bus.m_axi_rdata;
                    rsp_resp_d   = bus.m_axi_rresp;
                    rsp_tvalid_d = 1'b1;
                    state_d      = ST_RSP;
                    if (bus.m_axi_rresp != 2'b00) begin
                        err_count_d = sat_inc(err_count_q);
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    state_d = ST_RDATA;
                end
            end

            ST_RSP: begin
                if (rsp_tvalid_q && bus.m_axis_rsp_tready) begin
                    rsp_tvalid_d = 1'b0;
                    cmd_tready_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end

            default: begin
                // Unreachable encoding: return to a quiet IDLE.
                state_d      = ST_IDLE;
                cmd_tready_d = 1'b0;
                awvalid_d    = 1'b0;
                wvalid_d     = 1'b0;
                arvalid_d    = 1'b0;
                bready_d     = 1'b0;
                rready_d     = 1'b0;
                rsp_tvalid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every valid/ready asynchronously.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cmd_tready_q <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            rsp_tvalid_q <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'h0;
            op_q         <= 1'b0;
            rsp_data_q   <= 32'h0000_0000;
            rsp_resp_q   <= 2'b00;
            busy_q       <= 1'b0;
            err_count_q  <= {ERR_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cmd_tready_q <= cmd_tready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            rready_q     <= rready_d;
            rsp_tvalid_q <= rsp_tvalid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            op_q         <= op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_resp_q   <= rsp_resp_d;
            busy_q       <= busy_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.s_axis_cmd_tready = cmd_tready_q;
    assign bus.m_axis_rsp_tdata  = rsp_data_q;
    assign bus.m_axis_rsp_tuser  = {rsp_resp_q, op_q};
    assign bus.m_axis_rsp_tvalid = rsp_tvalid_q;
    assign bus.m_axi_awaddr      = addr_q;
    assign bus.m_axi_awprot      = 3'b000;
    assign bus.m_axi_awvalid     = awvalid_q;
    assign bus.m_axi_wdata       = wdata_q;
    assign bus.m_axi_wstrb       = wstrb_q;
    assign bus.m_axi_wvalid      = wvalid_q;
    assign bus.m_axi_bready      = bready_q;
    assign bus.m_axi_araddr      = addr_q;
    assign bus.m_axi_arprot      = 3'b000;
    assign bus.m_axi_arvalid     = arvalid_q;
    assign bus.m_axi_rready      = rready_q;
    assign busy                  = busy_q;
    assign err_count             = err_count_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_cmd_master
// Drives commands into axi_lite_cmd_master, models an AXI4-Lite subordinate
// with programmable ready delays and response codes, and compares every
// response beat against a queue of expected results pushed when each command
// is driven. The error counter is built narrow here so that saturation is
// reachable in a short run.
// -----------------------------------------------------------------------------
module tb_axi_lite_cmd_master;

    localparam int ERR_W = 4;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  user;
        int          lat;
    } exp_t;

    logic             aclk;
    logic             aresetn;
    logic             busy;
    logic [ERR_W-1:0] err_count;

    axi_lite_cmd_master_if bus_if ();

    axi_lite_cmd_master #(.ERR_CNT_W(ERR_W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus_if),
        .busy      (busy),
        .err_count (err_count)
    );

    // Scoreboard and counters
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_accept_cyc = 0;
    int          last_rsp_hs_cyc = 0;
    int          rsp_first_cyc   = 0;
    int          n_accept = 0;
    logic        rsp_seen = 1'b0;
    logic        rsp_hold = 1'b0;

    // Subordinate configuration and observations
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;
    logic        b_fire = 1'b0, r_fire = 1'b0;
    logic [31:0] aw_ref, ar_ref;
    logic [35:0] w_ref;
    logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;
    int          aw_hs_cyc = 0, ar_hold = 0, b_hs_cnt = 0, unstable = 0;
    logic        saw_aw_only = 1'b0;
    logic [ERR_W-1:0] exp_err = '0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // AXI4-Lite subordinate: readies and responses change only on the falling edge.
    initial begin
        bus_if.m_axi_awready = 1'b0;
        bus_if.m_axi_wready  = 1'b0;
        bus_if.m_axi_arready = 1'b0;
        bus_if.m_axi_bvalid  = 1'b0;
        bus_if.m_axi_bresp   = 2'b00;
        bus_if.m_axi_rvalid  = 1'b0;
        bus_if.m_axi_rresp   = 2'b00;
        bus_if.m_axi_rdata   = 32'h0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                bus_if.m_axi_awready = 1'b0;
                bus_if.m_axi_wready  = 1'b0;
                bus_if.m_axi_arready = 1'b0;
                bus_if.m_axi_bvalid  = 1'b0;
                bus_if.m_axi_rvalid  = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
                b_fire = 1'b0; r_fire = 1'b0;
            end else begin
                if (b_fire) begin bus_if.m_axi_bvalid = 1'b0; b_fire = 1'b0; end
                if (r_fire) begin bus_if.m_axi_rvalid = 1'b0; r_fire = 1'b0; end
                if (aw_seen && w_seen && !bus_if.m_axi_bvalid) begin
                    bus_if.m_axi_bvalid = 1'b1;
                    bus_if.m_axi_bresp  = cfg_bresp;
                    aw_seen = 1'b0; w_seen = 1'b0;
                end
                if (ar_seen && !bus_if.m_axi_rvalid) begin
                    bus_if.m_axi_rvalid = 1'b1;
                    bus_if.m_axi_rdata  = cfg_rdata;
                    bus_if.m_axi_rresp  = cfg_rresp;
                    ar_seen = 1'b0;
                end
                if (bus_if.m_axi_bvalid && bus_if.m_axi_bready) begin b_fire = 1'b1; b_hs_cnt++; end
                if (bus_if.m_axi_rvalid && bus_if.m_axi_rready) r_fire = 1'b1;
                if (bus_if.m_axi_awvalid && !bus_if.m_axi_wvalid) saw_aw_only = 1'b1;

                if (bus_if.m_axi_awvalid) begin
                    if (aw_cnt == 0) aw_ref = bus_if.m_axi_awaddr;
                    else if (aw_ref != bus_if.m_axi_awaddr) unstable++;
                    bus_if.m_axi_awready = (aw_cnt >= aw_dly);
                    aw_cnt++;
                    if (bus_if.m_axi_awready) begin
                        aw_seen = 1'b1; cap_awaddr = bus_if.m_axi_awaddr; aw_hs_cyc = cyc;
                    end
                end else begin
                    bus_if.m_axi_awready = 1'b0; aw_cnt = 0;
                end

                if (bus_if.m_axi_wvalid) begin
                    if (w_cnt == 0) w_ref = {bus_if.m_axi_wstrb, bus_if.m_axi_wdata};
                    else if (w_ref != {bus_if.m_axi_wstrb, bus_if.m_axi_wdata}) unstable++;
                    bus_if.m_axi_wready = (w_cnt >= w_dly);
                    w_cnt++;
                    if (bus_if.m_axi_wready) begin
                        w_seen = 1'b1; cap_wdata = bus_if.m_axi_wdata; cap_wstrb = bus_if.m_axi_wstrb;
                    end
                end else begin
                    bus_if.m_axi_wready = 1'b0; w_cnt = 0;
                end

                if (bus_if.m_axi_arvalid) begin
                    if (ar_cnt == 0) ar_ref = bus_if.m_axi_araddr;
                    else if (ar_ref != bus_if.m_axi_araddr) unstable++;
                    bus_if.m_axi_arready = (ar_cnt >= ar_dly);
                    ar_cnt++;
                    if (bus_if.m_axi_arready) begin
                        ar_seen = 1'b1; cap_araddr = bus_if.m_axi_araddr; ar_hold = ar_cnt;
                    end
                end else begin
                    bus_if.m_axi_arready = 1'b0; ar_cnt = 0;
                end
            end
        end
    end

    // Response sink: pops the scoreboard on every accepted response beat.
    initial begin
        exp_t e;
        bus_if.m_axis_rsp_tready = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                rsp_seen = 1'b0;
                bus_if.m_axis_rsp_tready = 1'b0;
            end else begin
                bus_if.m_axis_rsp_tready = !rsp_hold;
                if (bus_if.m_axis_rsp_tvalid && !rsp_seen) begin
                    rsp_seen = 1'b1;
                    rsp_first_cyc = cyc;
                end
                if (bus_if.m_axis_rsp_tvalid && bus_if.m_axis_rsp_tready) begin
                    rsp_seen = 1'b0;
                    last_rsp_hs_cyc = cyc;
                    check_eq("rsp_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq("rsp_tdata", 64'(bus_if.m_axis_rsp_tdata), 64'(e.data));
                        check_eq("rsp_tuser", 64'(bus_if.m_axis_rsp_tuser), 64'(e.user));
                        if (e.lat != 0) check_eq("rsp_latency", 64'(rsp_first_cyc - last_accept_cyc), 64'(e.lat));
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [31:0] exp_data,
                            input logic [2:0] exp_user, input int lat);
        exp_t e;
        int   n;
        e.data = exp_data;
        e.user = exp_user;
        e.lat  = lat;
        @(negedge aclk);
        bus_if.s_axis_cmd_tdata  = {wd, addr};
        bus_if.s_axis_cmd_tuser  = {strb, op};
        bus_if.s_axis_cmd_tvalid = 1'b1;
        sb.push_back(e);
        n = 0;
        while (!bus_if.s_axis_cmd_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check_eq("cmd_accept", 64'(bus_if.s_axis_cmd_tready), 64'd1);
        last_accept_cyc = cyc;
        n_accept++;
        @(posedge aclk);
        #1;
        bus_if.s_axis_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge aclk);
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check_eq("idle_reached", 64'(sb.size() == 0 && !busy), 64'd1);
    endtask

    // Main sequence
    initial begin
        int   acc0, n, viol, b0;
        logic [1:0] r;
        aresetn = 1'b0;
        bus_if.s_axis_cmd_tdata  = 64'h0;
        bus_if.s_axis_cmd_tuser  = 5'h0;
        bus_if.s_axis_cmd_tvalid = 1'b0;
        repeat (3) @(negedge aclk);
        check_eq("rst_valids", 64'({bus_if.m_axi_awvalid, bus_if.m_axi_wvalid, bus_if.m_axi_arvalid,
                                    bus_if.m_axis_rsp_tvalid}), 64'd0);
        check_eq("rst_readies", 64'({bus_if.m_axi_bready, bus_if.m_axi_rready, bus_if.s_axis_cmd_tready}), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err_count", 64'(err_count), 64'd0);
        check_eq("rst_addr_data", 64'({bus_if.m_axi_awaddr, bus_if.m_axi_wdata}), 64'd0);
        check_eq("rst_prot", 64'({bus_if.m_axi_awprot, bus_if.m_axi_arprot}), 64'd0);
        #2 aresetn = 1'b1;

        // Write, always-ready subordinate
        send_cmd(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 32'h0, 3'b001, 3);
        wait_idle();
        check_eq("wr_awaddr", 64'(cap_awaddr), 64'h4);
        check_eq("wr_wdata", 64'(cap_wdata), 64'h1234_5678);
        check_eq("wr_wstrb", 64'(cap_wstrb), 64'hF);
        check_eq("wr_aw_cycle", 64'(aw_hs_cyc - last_accept_cyc), 64'd1);

        // Read with arready delayed by 3 cycles
        ar_dly = 3; cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
        send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'hCAFE_F00D, 3'b000, 6);
        wait_idle();
        check_eq("rd_arvalid_cycles", 64'(ar_hold), 64'd4);
        check_eq("rd_araddr", 64'(cap_araddr), 64'h8);
        ar_dly = 0;

        // Write with W accepted before AW, unaligned address and zero strobe
        @(posedge aclk); #1;
        aw_dly = 2; saw_aw_only = 1'b0; b0 = b_hs_cnt;
        send_cmd(1'b1, 32'h0000_0103, 32'hA5A5_0001, 4'h0, 32'h0, 3'b001, 5);
        wait_idle();
        check_eq("wfirst_aw_only_seen", 64'(saw_aw_only), 64'd1);
        check_eq("wfirst_b_count", 64'(b_hs_cnt - b0), 64'd1);
        check_eq("wfirst_awaddr_aligned", 64'(cap_awaddr), 64'h100);
        check_eq("wfirst_zero_strb", 64'(cap_wstrb), 64'h0);
        check_eq("wfirst_wdata", 64'(cap_wdata), 64'hA5A5_0001);
        check_eq("bus_stability", 64'(unstable), 64'd0);
        aw_dly = 0;

        // Read of an unmapped register with SLVERR
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
        send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 3'b100, 3);
        wait_idle();
        exp_err = 4'd1;
        check_eq("err_first", 64'(err_count), 64'(exp_err));
        cfg_rresp = 2'b00;

        // Error responses beyond the counter range
        for (int i = 0; i < 16; i++) begin
            r = (i % 3 == 0) ? 2'b01 : ((i % 3 == 1) ? 2'b10 : 2'b11);
            cfg_bresp = r;
            send_cmd(1'b1, 32'h0000_0200 + 32'(4 * i), 32'(i), 4'hF, 32'h0, {r, 1'b1}, 3);
            wait_idle();
            if (exp_err != {ERR_W{1'b1}}) exp_err = exp_err + 4'd1;
            check_eq("err_sat", 64'(err_count), 64'(exp_err));
        end
        cfg_bresp = 2'b00;
        send_cmd(1'b1, 32'h0000_0300, 32'h0, 4'hF, 32'h0, 3'b001, 3);
        wait_idle();
        check_eq("err_ok_no_change", 64'(err_count), 64'(exp_err));

        // Response backpressure with a second command pending
        @(posedge aclk); #1;
        rsp_hold = 1'b1; cfg_rdata = 32'hAAAA_5555; acc0 = n_accept;
        fork
            begin
                send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hAAAA_5555, 3'b000, 3);
                send_cmd(1'b1, 32'h0000_0014, 32'h1111_2222, 4'hF, 32'h0, 3'b001, 3);
            end
        join_none
        n = 0;
        while (!bus_if.m_axis_rsp_tvalid && n < 50) begin @(negedge aclk); n++; end
        check_eq("bp_rsp_valid", 64'(bus_if.m_axis_rsp_tvalid), 64'd1);
        viol = 0;
        repeat (10) begin
            @(negedge aclk);
            if (bus_if.s_axis_cmd_tready || bus_if.m_axi_awvalid || bus_if.m_axi_wvalid ||
                bus_if.m_axi_arvalid || bus_if.m_axi_bready || bus_if.m_axi_rready ||
                !busy || !bus_if.m_axis_rsp_tvalid) viol++;
        end
        check_eq("bp_hold_quiet", 64'(viol), 64'd0);
        @(posedge aclk); #1;
        rsp_hold = 1'b0;
        n = 0;
        while (n_accept < acc0 + 2 && n < 50) begin @(negedge aclk); n++; end
        check_eq("bp_accepts", 64'(n_accept - acc0), 64'd2);
        check_eq("bp_accept_gap", 64'(last_accept_cyc - last_rsp_hs_cyc), 64'd1);
        wait_idle();
        check_eq("bp_wdata", 64'(cap_wdata), 64'h1111_2222);

        // Reset while awvalid is high, then a fresh write
        aw_dly = 5;
        send_cmd(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF, 32'h0, 3'b001, 0);
        @(negedge aclk); #2;
        check_eq("rst_mid_awvalid_before", 64'(bus_if.m_axi_awvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check_eq("rst_mid_valids", 64'({bus_if.m_axi_awvalid, bus_if.m_axi_wvalid, bus_if.m_axi_arvalid,
                                        bus_if.m_axis_rsp_tvalid}), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_err", 64'(err_count), 64'd0);
        sb.delete();
        @(negedge aclk); #2;
        aresetn = 1'b1;
        aw_dly = 0; exp_err = '0;
        send_cmd(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 32'h0, 3'b001, 3);
        wait_idle();
        check_eq("post_rst_awaddr", 64'(cap_awaddr), 64'h20);
        check_eq("post_rst_wdata", 64'(cap_wdata), 64'h0BAD_F00D);
        check_eq("post_rst_wstrb", 64'(cap_wstrb), 64'h3);
        check_eq("post_rst_err", 64'(err_count), 64'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
